// File: rtl/connect4_pkg.sv
// Shared types and constants for the connect-four turn controller.
// Contents:
//   cell_t       - 2-bit board cell (CELL_EMPTY, P1, P2)
//   ROWS_C/COLS_C - default board geometry (6 rows x 7 columns)
//   board_t      - packed board, [row][col], row 0 at the top
//   ctrl_state_t - controller FSM states
//   other_player - returns the opponent of a player id
package connect4_pkg;

  typedef logic [1:0] cell_t;

  localparam cell_t CELL_EMPTY = 2'b00;
  localparam cell_t P1         = 2'b01;
  localparam cell_t P2         = 2'b10;

  localparam int unsigned ROWS_C = 6;
  localparam int unsigned COLS_C = 7;

  typedef cell_t [0:ROWS_C-1][0:COLS_C-1] board_t;

  typedef enum logic [2:0] {
    StIdle,
    StWaitMove,
    StCheck,
    StCheckWait,
    StGameOver
  } ctrl_state_t;

  function automatic cell_t other_player(cell_t p);
    return (p == P1) ? P2 : P1;
  endfunction

endpackage

// File: rtl/connect4_column_heights.sv
// Per-column fill heights for the connect-four board.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   clear           - zero every column height (new game)
//   inc, inc_col    - add one piece to column inc_col (saturates at ROWS)
//   sel_col         - column whose landing row is reported on drop_row
//   col_full        - one bit per column, set when the column holds ROWS pieces
//   drop_row        - row a piece dropped into sel_col would occupy
//   first_free_col  - lowest-index column that is not full (0 if none)
module connect4_column_heights
  import connect4_pkg::*;
#(
  parameter int unsigned ROWS = ROWS_C,
  parameter int unsigned COLS = COLS_C
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            inc,
  input  logic [2:0]      inc_col,
  input  logic [2:0]      sel_col,
  output logic [COLS-1:0] col_full,
  output logic [2:0]      drop_row,
  output logic [2:0]      first_free_col
);

  logic [2:0] height_q [COLS];
  logic [2:0] height_d [COLS];
  logic [2:0] sel_height;
  logic       found;

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      height_d[c] = height_q[c];
      if (clear) begin
        height_d[c] = '0;
      end else if (inc && (inc_col == 3'(c)) && (height_q[c] < 3'(ROWS))) begin
        height_d[c] = height_q[c] + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < COLS; c++) begin
        height_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < COLS; c++) begin
        height_q[c] <= height_d[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      col_full[c] = (height_q[c] >= 3'(ROWS));
    end
  end

  // Landing row counts up from the bottom; meaningless for a full column,
  // which the controller rejects before using it.
  always_comb begin
    sel_height = '0;
    for (int c = 0; c < COLS; c++) begin
      if (sel_col == 3'(c)) begin
        sel_height = height_q[c];
      end
    end
    drop_row = 3'(ROWS - 1) - sel_height;
  end

  always_comb begin
    first_free_col = '0;
    found          = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (!found && !col_full[c]) begin
        first_free_col = 3'(c);
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/connect4_game_ctrl.sv
// Turn sequencer for the connect-four game: owns the board, drops pieces,
// runs the win-checker handshake, alternates players, declares win or draw.
// Optional feature: define TURN_TIMEOUT_EN to build the per-turn idle timer
// that auto-drops the current player's piece into the first non-full column.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   start                      - pulse: clear board, begin a new game
//   move_valid, move_col       - offered move; move_ready accepts it
//   move_reject                - pulse one cycle after an illegal offer
//   board                      - registered board, read by checker and renderer
//   check_en, win_flag, winner_id - win-checker handshake
//   current_player             - player to move
//   last_row, last_col         - position of the most recent drop
//   game_over, winner, draw    - game result
//   turn_timeout               - pulse in the cycle an auto-move is taken
module connect4_game_ctrl
  import connect4_pkg::*;
#(
  parameter int unsigned ROWS         = ROWS_C,
  parameter int unsigned COLS         = COLS_C,
  parameter int unsigned CHECK_LAT    = 1,
  parameter int unsigned TURN_TIMEOUT = 50_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          move_valid,
  input  logic [2:0]                    move_col,
  output logic                          move_ready,
  output logic                          move_reject,
  output cell_t [0:ROWS-1][0:COLS-1]    board,
  output logic                          check_en,
  input  logic                          win_flag,
  input  logic [1:0]                    winner_id,
  output logic [1:0]                    current_player,
  output logic [2:0]                    last_row,
  output logic [2:0]                    last_col,
  output logic                          game_over,
  output logic [1:0]                    winner,
  output logic                          draw,
  output logic                          turn_timeout
);

  localparam int unsigned Cells = ROWS * COLS;
  localparam int unsigned CntW  = $clog2(Cells + 1);

  ctrl_state_t                 state_q, state_d;
  cell_t [0:ROWS-1][0:COLS-1]  board_q, board_d;
  cell_t                       player_q, player_d;
  logic [CntW-1:0]             count_q, count_d;
  logic [2:0]                  last_row_q, last_row_d;
  logic [2:0]                  last_col_q, last_col_d;
  cell_t                       winner_q, winner_d;
  logic                        draw_q, draw_d;
  logic                        reject_q, reject_d;
  logic [2:0]                  lat_cnt_q, lat_cnt_d;

  logic [COLS-1:0] col_full;
  logic [2:0]      drop_row;
  logic [2:0]      first_free_col;
  logic [2:0]      drop_col;
  logic            auto_move;
  logic            take;
  logic            illegal;
  logic            heights_clear;
  logic            heights_inc;

  // Auto-move targets the first free column; otherwise the offered column.
  assign drop_col = auto_move ? first_free_col : move_col;
  assign take     = move_valid | auto_move;

  always_comb begin
    illegal = ({29'd0, move_col} >= COLS);
    for (int c = 0; c < COLS; c++) begin
      if ((move_col == 3'(c)) && col_full[c]) begin
        illegal = 1'b1;
      end
    end
  end

  connect4_column_heights #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_heights (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (heights_clear),
    .inc            (heights_inc),
    .inc_col        (drop_col),
    .sel_col        (drop_col),
    .col_full       (col_full),
    .drop_row       (drop_row),
    .first_free_col (first_free_col)
  );

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned TimerW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;

  logic [TimerW-1:0] timer_q, timer_d;

  // A user offer in the expiry cycle takes precedence over the auto-move.
  assign auto_move = (state_q == StWaitMove) && !start && !move_valid &&
                     (timer_q == TimerW'(TURN_TIMEOUT - 1));

  always_comb begin
    timer_d = timer_q + TimerW'(1);
    if ((state_q != StWaitMove) || start || move_valid || auto_move) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unused_turn_timeout;
  assign unused_turn_timeout = ^TURN_TIMEOUT;
  assign auto_move           = 1'b0;
`endif

  assign turn_timeout = auto_move;

  always_comb begin
    state_d       = state_q;
    board_d       = board_q;
    player_d      = player_q;
    count_d       = count_q;
    last_row_d    = last_row_q;
    last_col_d    = last_col_q;
    winner_d      = winner_q;
    draw_d        = draw_q;
    reject_d      = 1'b0;
    lat_cnt_d     = lat_cnt_q;
    heights_clear = 1'b0;
    heights_inc   = 1'b0;

    if (start) begin
      state_d       = StWaitMove;
      board_d       = '0;
      player_d      = P1;
      count_d       = '0;
      last_row_d    = '0;
      last_col_d    = '0;
      winner_d      = CELL_EMPTY;
      draw_d        = 1'b0;
      heights_clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StWaitMove: begin
          if (take) begin
            if (!auto_move && illegal) begin
              reject_d = 1'b1;
            end else begin
              for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                  if ((drop_row == 3'(r)) && (drop_col == 3'(c))) begin
                    board_d[r][c] = player_q;
                  end
                end
              end
              heights_inc = 1'b1;
              count_d     = count_q + CntW'(1);
              last_row_d  = drop_row;
              last_col_d  = drop_col;
              state_d     = StCheck;
            end
          end
        end
        StCheck: begin
          lat_cnt_d = '0;
          state_d   = StCheckWait;
        end
        StCheckWait: begin
          if (lat_cnt_q == 3'(CHECK_LAT - 1)) begin
            if (win_flag) begin
              winner_d = winner_id;
              state_d  = StGameOver;
            end else if (count_q == CntW'(Cells)) begin
              draw_d  = 1'b1;
              state_d = StGameOver;
            end else begin
              player_d = other_player(player_q);
              state_d  = StWaitMove;
            end
          end else begin
            lat_cnt_d = lat_cnt_q + 3'd1;
          end
        end
        StGameOver: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      board_q    <= '0;
      player_q   <= P1;
      count_q    <= '0;
      last_row_q <= '0;
      last_col_q <= '0;
      winner_q   <= CELL_EMPTY;
      draw_q     <= 1'b0;
      reject_q   <= 1'b0;
      lat_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      player_q   <= player_d;
      count_q    <= count_d;
      last_row_q <= last_row_d;
      last_col_q <= last_col_d;
      winner_q   <= winner_d;
      draw_q     <= draw_d;
      reject_q   <= reject_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

  assign move_ready     = (state_q == StWaitMove);
  assign check_en       = (state_q == StCheck) || (state_q == StCheckWait);
  assign game_over      = (state_q == StGameOver);
  assign move_reject    = reject_q;
  assign board          = board_q;
  assign current_player = player_q;
  assign last_row       = last_row_q;
  assign last_col       = last_col_q;
  assign winner         = winner_q;
  assign draw           = draw_q;

endmodule

// File: tb/tb_connect4_game_ctrl.sv
// Self-checking bench for connect4_game_ctrl (default 6x7 board, CHECK_LAT 1).
// Stimulus and checks are aligned to the falling clock edge.
module tb_connect4_game_ctrl;
  import connect4_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       move_valid;
  logic [2:0] move_col;
  logic       move_ready;
  logic       move_reject;
  board_t     board;
  logic       check_en;
  logic       win_flag;
  logic [1:0] winner_id;
  logic [1:0] current_player;
  logic [2:0] last_row;
  logic [2:0] last_col;
  logic       game_over;
  logic [1:0] winner;
  logic       draw;
  logic       turn_timeout;

  connect4_game_ctrl #(
    .ROWS         (6),
    .COLS         (7),
    .CHECK_LAT    (1),
    .TURN_TIMEOUT (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .move_valid     (move_valid),
    .move_col       (move_col),
    .move_ready     (move_ready),
    .move_reject    (move_reject),
    .board          (board),
    .check_en       (check_en),
    .win_flag       (win_flag),
    .winner_id      (winner_id),
    .current_player (current_player),
    .last_row       (last_row),
    .last_col       (last_col),
    .game_over      (game_over),
    .winner         (winner),
    .draw           (draw),
    .turn_timeout   (turn_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int col;
    bit rej;
    int row;
  } vec_t;

  typedef struct {
    bit         rej;
    int         row;
    int         col;
    logic [1:0] player;
  } exp_t;

  int     n_cmp;
  int     n_err;
  exp_t   sb[$];
  board_t tb_board;
  int     tb_h[7];
  int     tb_count;
  cell_t  tb_player;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    tb_board  = '0;
    for (int c = 0; c < 7; c++) tb_h[c] = 0;
    tb_count  = 0;
    tb_player = P1;
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    chk("start_ready", move_ready, 1);
    chk("start_board_clear", board, '0);
    chk("start_game_over", game_over, 0);
    chk("start_player", current_player, P1);
  endtask

  task automatic play(input int col, input bit rej, input int row, input bit w,
                      input logic [1:0] wid);
    exp_t e;
    exp_t got;
    e.rej    = rej;
    e.row    = row;
    e.col    = col;
    e.player = tb_player;
    chk("ready_before_move", move_ready, 1);
    sb.push_back(e);
    move_valid = 1'b1;
    move_col   = 3'(col);
    win_flag   = w;
    winner_id  = wid;
    @(negedge clk);
    move_valid = 1'b0;
    move_col   = '0;
    got = sb.pop_front();
    if (got.rej) begin
      chk("reject_pulse", move_reject, 1);
      chk("reject_no_check", check_en, 0);
      chk("reject_board", board, tb_board);
      chk("reject_player", current_player, got.player);
      @(negedge clk);
      chk("reject_one_cycle", move_reject, 0);
      chk("reject_stay_ready", move_ready, 1);
    end else begin
      tb_board[got.row][got.col] = got.player;
      tb_h[got.col]++;
      tb_count++;
      chk("accept_no_reject", move_reject, 0);
      chk("check_en_t1", check_en, 1);
      chk("last_row", last_row, got.row);
      chk("last_col", last_col, got.col);
      chk("board_after_drop", board, tb_board);
      chk("ready_low_t1", move_ready, 0);
      @(negedge clk);
      chk("check_en_t2", check_en, 1);
      @(negedge clk);
      chk("check_en_t3", check_en, 0);
      win_flag  = 1'b0;
      winner_id = 2'b00;
      if (w) begin
        chk("win_game_over", game_over, 1);
        chk("win_winner", winner, wid);
        chk("win_draw", draw, 0);
        chk("win_ready", move_ready, 0);
      end else if (tb_count == 42) begin
        chk("draw_game_over", game_over, 1);
        chk("draw_flag", draw, 1);
        chk("draw_winner", winner, 0);
        chk("draw_ready", move_ready, 0);
      end else begin
        tb_player = (tb_player == P1) ? P2 : P1;
        chk("player_toggle", current_player, tb_player);
        chk("ready_t3", move_ready, 1);
        chk("no_game_over", game_over, 0);
      end
    end
  endtask

  vec_t vecs[10];
  int   win_cols[7];
  int   win_rows[7];
  int   fired_at;
  bit   tt_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    move_valid = 1'b0;
    move_col   = '0;
    win_flag   = 1'b0;
    winner_id  = 2'b00;
    model_clear();

    vecs[0] = '{col: 3, rej: 0, row: 5};
    vecs[1] = '{col: 0, rej: 0, row: 5};
    vecs[2] = '{col: 0, rej: 0, row: 4};
    vecs[3] = '{col: 0, rej: 0, row: 3};
    vecs[4] = '{col: 0, rej: 0, row: 2};
    vecs[5] = '{col: 0, rej: 0, row: 1};
    vecs[6] = '{col: 0, rej: 0, row: 0};
    vecs[7] = '{col: 0, rej: 1, row: 0};
    vecs[8] = '{col: 7, rej: 1, row: 0};
    vecs[9] = '{col: 6, rej: 0, row: 5};
    win_cols = '{0, 0, 1, 1, 2, 2, 3};
    win_rows = '{5, 4, 5, 4, 5, 4, 5};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", move_ready, 0);
    chk("rst_board", board, '0);
    chk("rst_player", current_player, P1);
    chk("rst_check_en", check_en, 0);
    chk("rst_game_over", game_over, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // IDLE ignores offered moves
    move_valid = 1'b1;
    move_col   = 3'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_no_reject", move_reject, 0);
      chk("idle_not_ready", move_ready, 0);
    end
    move_valid = 1'b0;
    chk("idle_board", board, '0);

    // Table: first drop, column fill, full-column and out-of-range rejects
    do_start();
    for (int i = 0; i < 10; i++) begin
      play(vecs[i].col, vecs[i].rej, vecs[i].row, 1'b0, 2'b00);
    end

    // Win for P1 on the bottom row
    do_start();
    for (int i = 0; i < 7; i++) begin
      play(win_cols[i], 1'b0, win_rows[i], (i == 6), (i == 6) ? P1 : CELL_EMPTY);
    end
    move_valid = 1'b1;
    move_col   = 3'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("over_no_reject", move_reject, 0);
      chk("over_board_frozen", board, tb_board);
      chk("over_no_check", check_en, 0);
      chk("over_held", game_over, 1);
    end
    move_valid = 1'b0;

    // start and a move in the same cycle: move ignored
    start      = 1'b1;
    move_valid = 1'b1;
    move_col   = 3'd2;
    @(negedge clk);
    start      = 1'b0;
    move_valid = 1'b0;
    model_clear();
    chk("restart_board", board, '0);
    chk("restart_ready", move_ready, 1);
    chk("restart_no_check", check_en, 0);
    chk("restart_game_over", game_over, 0);
    chk("restart_winner", winner, 0);

    // Fill the whole board with the checker reporting no win
    do_start();
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        play(c, 1'b0, 5 - tb_h[c], 1'b0, 2'b00);
      end
    end

    // Asynchronous reset in the middle of CHECK_WAIT
    do_start();
    move_valid = 1'b1;
    move_col   = 3'd4;
    @(negedge clk);
    move_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_check_en", check_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_board", board, '0);
    chk("mid_rst_check_en", check_en, 0);
    chk("mid_rst_ready", move_ready, 0);
    chk("mid_rst_player", current_player, P1);
    chk("mid_rst_last_row", last_row, 0);
    chk("mid_rst_last_col", last_col, 0);
    chk("mid_rst_game_over", game_over, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    chk("post_rst_idle", move_ready, 0);

    // Turn timeout
    do_start();
`ifdef TURN_TIMEOUT_EN
    fired_at = -1;
    for (int k = 0; k < 40; k++) begin
      if (turn_timeout) begin
        fired_at = k;
        break;
      end
      @(negedge clk);
    end
    chk("timeout_cycle", 32'(fired_at), 32'd15);
    if (fired_at >= 0) begin
      @(negedge clk);
      tb_board[5][0] = P1;
      chk("timeout_pulse_one_cycle", turn_timeout, 0);
      chk("timeout_board", board, tb_board);
      chk("timeout_last_col", last_col, 0);
      chk("timeout_check_en", check_en, 1);
    end
`else
    tt_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      tt_seen = tt_seen | turn_timeout;
    end
    chk("no_timeout_pulse", tt_seen, 0);
    chk("no_timeout_ready", move_ready, 1);
    chk("no_timeout_board", board, '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/connect4_game_ctrl.md
Name: connect4_game_ctrl

Overview:
Turn sequencer for the 6x7 four-in-a-row game.
- Owns the board register and accepts column moves from the input front end.
- Drops the piece into the lowest free row, then runs the win-checker handshake (check_en / win_flag / winner_id).
- Alternates players and declares win or draw.
- Sits between the input/debounce logic and the checker/VGA renderer, which both read its board output.

Parameters:
ROWS, 6, board rows; row 0 is the top, row ROWS-1 is the bottom.
COLS, 7, board columns; column 0 is the leftmost.
CHECK_LAT, 1, number of CHECK_WAIT cycles before win_flag is sampled (1..7).
TURN_TIMEOUT, 50_000_000, idle cycles per turn before an auto-move (used only with the optional feature).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; clears the board and begins a new game.
move_valid  in  1  a move is offered on move_col.
move_col  in  3  target column.
move_ready  out  1  controller accepts a move this cycle.
move_reject  out  1  one-cycle pulse: the offered move was illegal.
board  out  2 x [0:ROWS-1][0:COLS-1]  registered board; 00 = empty, 01 = P1, 10 = P2.
check_en  out  1  win-checker enable.
win_flag  in  1  win-checker result.
winner_id  in  2  win-checker winner.
current_player  out  2  player to move (01 or 10).
last_row  out  3  row of the most recent drop.
last_col  out  3  column of the most recent drop.
game_over  out  1  high in GAME_OVER.
winner  out  2  winning player id; 00 on draw or while a game is in progress.
draw  out  1  board filled with no win.
turn_timeout  out  1  one-cycle pulse when an auto-move fires; tied to 0 without the optional feature.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; board all 00; column heights 0; move_count 0; current_player 01.
  - All other outputs are 0.
  - Reset asserted mid-game aborts the game immediately.
- States: IDLE, WAIT_MOVE, CHECK, CHECK_WAIT, GAME_OVER.
- start has priority in every state. On the next cycle: board cleared, heights 0, move_count 0, player 01, winner/draw/game_over 0, state WAIT_MOVE. Any move offered in that same cycle is ignored.
- move_ready = 1 only in WAIT_MOVE.
- Handshake at cycle T means move_valid & move_ready.
  - Illegal move (move_col >= COLS, or height[move_col] == ROWS): move_reject = 1 at T+1; no board change; stay in WAIT_MOVE.
  - Legal move: board[ROWS-1-height[c]][c] <= current_player at the end of T. height[c] increments; move_count increments; last_row and last_col are updated; state CHECK at T+1.
- check_en = 1 throughout CHECK (1 cycle) and CHECK_WAIT (CHECK_LAT cycles).
- win_flag and winner_id are sampled in the last CHECK_WAIT cycle (T+1+CHECK_LAT). In the following cycle:
  - win_flag = 1: state GAME_OVER, winner <= winner_id.
  - else if move_count == ROWS*COLS: state GAME_OVER, draw = 1.
  - else: current_player toggles 01<->10, state WAIT_MOVE.
- Default timing (CHECK_LAT = 1): accept at T, check_en at T+1 and T+2, next move accepted at T+3 at the earliest.
- GAME_OVER: board frozen, move_ready 0, check_en 0. Only start or reset leaves this state.
- IDLE: move_valid is ignored and move_reject is never pulsed.
- height is 3 bits and saturates at ROWS; it never wraps.

Optional Feature:
Macro: TURN_TIMEOUT_EN.
- Defined:
  - A per-turn counter runs in WAIT_MOVE; it clears on any handshake (legal or illegal) and on entry to WAIT_MOVE.
  - When it reaches TURN_TIMEOUT-1, an auto-move drops current_player's piece into the lowest-index non-full column.
  - This proceeds exactly like a legal handshake; turn_timeout pulses in the same cycle as the board write.
  - If move_valid arrives in the expiry cycle, the user move wins and the timer clears.
- Undefined: no counter is built; turn_timeout is a constant 0.

Decomposition:
- Package connect4_pkg:
  - cell_t (2-bit), constants CELL_EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10.
  - ROWS_C = 6, COLS_C = 7.
  - board_t typedef.
  - ctrl_state_t enum.
- Sub-module connect4_column_heights:
  - Per-column height registers with clear and increment.
  - Combinational outputs: col_full[COLS], drop_row for the selected column, and first_free_col (used by the timeout auto-move).

Test Plan:
- Reset, start, P1 plays col 3 -> board[5][3] = 01, last_row 5, last_col 3, check_en high for exactly 2 cycles, current_player 10 at T+3.
- Six moves into col 0, then a seventh -> seventh gives move_reject pulse, board unchanged, same player still to move.
- move_col = 7 -> move_reject; move_count unchanged.
- P1 cols 0,1,2,3 interleaved with P2 cols 0,1,2 -> checker returns win_flag 1, winner_id 01 -> game_over 1, winner 01, move_ready 0; further moves ignored.
- Fill the board in a no-win pattern (42 moves) -> draw 1, winner 00.
- rst_n pulsed low mid-CHECK_WAIT -> all outputs 0 immediately, board cleared, state IDLE.
- With TURN_TIMEOUT_EN and TURN_TIMEOUT = 16 -> after 16 idle cycles, turn_timeout pulses and the piece lands in col 0.
